// File: rtl/vga_sync_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_controller_if
//  Description : Raster timing bundle between the pixel timer, the VGA sync
//                controller and the pixel-data/RGB generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_controller_if;
    logic       pixel_en;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;

    // Sync controller side: consumes the pixel enable, produces the raster.
    modport slave (
        input  pixel_en,
        output hsync, vsync, display_on, x, y, line_start, frame_start
    );

    // Pixel timer / raster consumer side.
    modport master (
        output pixel_en,
        input  hsync, vsync, display_on, x, y, line_start, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_controller
//  Description : 640x480@60 VGA raster sequencer. Horizontal/vertical position
//                counters advanced by a pixel enable, with registered
//                active-low syncs, display-active flag and line/frame strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  wire logic              clk,
    input  wire logic              reset,
    vga_sync_controller_if.slave   bus
);

    // Totals must fit the 10-bit counters (<= 1024).
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] C_H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_H_ACTIVE    = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACTIVE    = 10'(V_ACTIVE);
    localparam logic [9:0] C_HSYNC_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HSYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] C_VSYNC_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VSYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_on_q, display_on_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    // Next position plus level decode of that next position, so levels land
    // on the same edge as the counters they describe.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (bus.pixel_en) begin
            if (x_q < C_H_LAST) begin
                x_d = x_q + 10'd1;
            end else begin
                x_d          = 10'd0;
                line_start_d = 1'b1;
                if (y_q == C_V_LAST) begin
                    y_d           = 10'd0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end
        end

        hsync_d      = !((x_d >= C_HSYNC_BEGIN) && (x_d < C_HSYNC_END));
        vsync_d      = !((y_d >= C_VSYNC_BEGIN) && (y_d < C_VSYNC_END));
        display_on_d = (x_d < C_H_ACTIVE) && (y_d < C_V_ACTIVE);
    end

    // State and output registers; reset parks at the last position so the
    // first enable wraps to (0,0) and raises both strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= C_H_LAST;
            y_q           <= C_V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.display_on  = display_on_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_controller
//  Description : Self-checking bench for vga_sync_controller. A full-size
//                instance and a reduced-timing instance share one pixel
//                enable; both are compared each clock with a raster model
//                derived from the number of enables since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_controller;

    // Reduced timing for the small instance: 30 pixels x 15 lines.
    localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 4;
    localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic pe    = 1'b0;

    int tests  = 0;
    int failed = 0;
    int n      = 0;      // enables since last reset release
    int last_fs = -1;    // enable count at last small-instance frame_start
    int hs_run = 0;      // consecutive clks with big-instance hsync low
    bit tied   = 1'b0;   // pixel_en continuously high phase

    vga_sync_controller_if big_if ();
    vga_sync_controller_if sm_if ();

    assign big_if.pixel_en = pe;
    assign sm_if.pixel_en  = pe;

    vga_sync_controller u_big (
        .clk   (clk),
        .reset (reset),
        .bus   (big_if.slave)
    );

    vga_sync_controller #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sm_if.slave)
    );

    always #5 clk = ~clk;

    // Expected {hsync,vsync,display_on,x,y,line_start,frame_start} after cnt
    // enables, where en says whether an enable landed on the latest edge.
    function automatic logic [24:0] model(input int cnt, input bit en,
                                          input int ha, input int hf, input int hs, input int hb,
                                          input int va, input int vf, input int vs, input int vb);
        int  ht, vt, xx, yy;
        logic h, v, d, ls, fs;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (cnt == 0)
            return {1'b1, 1'b1, 1'b0, 10'(ht - 1), 10'(vt - 1), 1'b0, 1'b0};
        xx = (cnt - 1) % ht;
        yy = ((cnt - 1) / ht) % vt;
        h  = !(xx >= ha + hf && xx < ha + hf + hs);
        v  = !(yy >= va + vf && yy < va + vf + vs);
        d  = (xx < ha) && (yy < va);
        ls = en && (xx == 0);
        fs = en && (xx == 0) && (yy == 0);
        return {h, v, d, 10'(xx), 10'(yy), ls, fs};
    endfunction

    function automatic logic [24:0] obs_big();
        return {big_if.hsync, big_if.vsync, big_if.display_on, big_if.x, big_if.y,
                big_if.line_start, big_if.frame_start};
    endfunction

    function automatic logic [24:0] obs_sm();
        return {sm_if.hsync, sm_if.vsync, sm_if.display_on, sm_if.x, sm_if.y,
                sm_if.line_start, sm_if.frame_start};
    endfunction

    task automatic check_vec(input string tag, input logic [24:0] o, input logic [24:0] e);
        tests++;
        assert (o === e) else begin
            failed++;
            $error("FAIL %s observed h/v/d/x/y/ls/fs=%b/%b/%b/%0d/%0d/%b/%b expected=%b/%b/%b/%0d/%0d/%b/%b",
                   tag, o[24], o[23], o[22], o[21:12], o[11:2], o[1], o[0],
                   e[24], e[23], e[22], e[21:12], e[11:2], e[1], e[0]);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        tests++;
        assert (o === e) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic check_both(input string tag, input bit en);
        check_vec({tag, "_big"}, obs_big(), model(n, en, 640, 16, 96, 48, 480, 10, 2, 33));
        check_vec({tag, "_small"}, obs_sm(),
                  model(n, en, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
    endtask

    // One clock: drive enable on the falling edge, check 1 ns after rising.
    task automatic step(input bit en, input string tag);
        @(negedge clk);
        pe = en;
        @(posedge clk);
        if (en) n++;
        #1;
        check_both(tag, en);
        if (sm_if.frame_start) begin
            if (last_fs >= 0) check_int("frame_period_small", n - last_fs, S_FRAME);
            last_fs = n;
        end
        if (!big_if.hsync) begin
            hs_run++;
        end else begin
            if (hs_run > 0 && tied) check_int("hsync_low_clks_tied", hs_run, 96);
            hs_run = 0;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check_both("reset", 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Nominal cadence: one enable every 4th clk, a bit over one line.
        for (int i = 0; i < 850; i++) begin
            repeat (3) step(1'b0, "nominal_gap");
            step(1'b1, "nominal");
        end

        // Enable tied high across a full line (covers the whole hsync pulse).
        tied = 1'b1;
        for (int i = 0; i < 1700; i++) step(1'b1, "tied");
        tied = 1'b0;
        hs_run = 0;

        // Irregular spacing: 1..7 clks between enables.
        for (int i = 0; i < 1500; i++) begin
            repeat ($urandom_range(0, 6)) step(1'b0, "rand_gap");
            step(1'b1, "rand_en");
        end

        // Advance to big-instance x=300, then reset mid-cycle.
        begin
            bit found = 1'b0;
            for (int i = 0; i < 4000 && !found; i++) begin
                step(1'b1, "seek");
                if (((n - 1) % 800) == 300) found = 1'b1;
            end
            tests++;
            assert (found) else begin
                failed++;
                $error("FAIL seek_x300 observed=not_reached expected=reached");
            end
        end
        #2;
        pe    = 1'b0;
        reset = 1'b1;
        #1;
        n       = 0;
        last_fs = -1;
        check_both("async_reset", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, "post_reset_idle");
        step(1'b1, "post_reset_first");
        check_int("post_reset_frame_start", int'(big_if.frame_start), 1);
        for (int i = 0; i < 40; i++) step(1'b1, "post_reset_run");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
